// File: rtl/piece_move_animator_if.sv
// Move-request handshake between the game FSM (master) and the piece
// move animator (slave).
interface piece_move_animator_if;
    logic       iMove_Valid;
    logic       iMove_Player;
    logic [3:0] iMove_Steps;
    logic       oMove_Ready;
    logic       oMove_Done;
    logic       oMoving;

    modport master (
        output iMove_Valid, iMove_Player, iMove_Steps,
        input  oMove_Ready, oMove_Done, oMoving
    );

    modport slave (
        input  iMove_Valid, iMove_Player, iMove_Steps,
        output oMove_Ready, oMove_Done, oMoving
    );
endinterface

// File: rtl/piece_move_animator.sv
// piece_move_animator: walks the P1/P2 board positions one cell per
// FRAMES_PER_STEP frame ticks so pieces visibly hop around the loop path.
// Optional feature macro: PIECE_CAPTURE_EN adds a one-cycle CAPTURE state
// after the final hop that sends a landed-on opponent back to cell 0.
module piece_move_animator #(
    parameter int NUM_CELLS       = 28,
    parameter int FRAMES_PER_STEP = 15,
    parameter int MAX_STEPS       = 6
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iFrame_Tick,
    piece_move_animator_if.slave        mv,
    output logic [5:0]                  oP1_Pos,
    output logic [5:0]                  oP2_Pos
);

    localparam logic [5:0] LAST_CELL   = 6'(NUM_CELLS - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] MAX_STEPS_C = 4'(MAX_STEPS);

`ifdef PIECE_CAPTURE_EN
    typedef enum logic [1:0] {IDLE, HOP, CAPTURE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOP, DONE} state_t;
`endif

    state_t     state_q, state_d;
    logic       player_q, player_d;
    logic [3:0] steps_q, steps_d;
    logic [7:0] frame_q, frame_d;
    logic [5:0] p1_q, p1_d;
    logic [5:0] p2_q, p2_d;
    logic       ready_q, moving_q, done_q;

    // Loop path: the last cell wraps back to the start cell.
    function automatic logic [5:0] next_cell(input logic [5:0] pos);
        return (pos == LAST_CELL) ? 6'd0 : pos + 6'd1;
    endfunction

    function automatic logic [3:0] clamp_steps(input logic [3:0] s);
        return (s > MAX_STEPS_C) ? MAX_STEPS_C : s;
    endfunction

    // Next-state logic: accept requests, pace hops by frame ticks, resolve capture.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        steps_d  = steps_q;
        frame_d  = frame_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        case (state_q)
            IDLE: begin
                // A tick arriving in the accept cycle is deliberately not counted.
                if (mv.iMove_Valid && ready_q) begin
                    player_d = mv.iMove_Player;
                    steps_d  = clamp_steps(mv.iMove_Steps);
                    frame_d  = 8'd0;
                    state_d  = (clamp_steps(mv.iMove_Steps) == 4'd0) ? DONE : HOP;
                end
            end
            HOP: begin
                if (iFrame_Tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = 8'd0;
                        steps_d = steps_q - 4'd1;
                        if (player_q) p2_d = next_cell(p2_q);
                        else          p1_d = next_cell(p1_q);
                        if (steps_q == 4'd1) begin
`ifdef PIECE_CAPTURE_EN
                            state_d = CAPTURE;
`else
                            state_d = DONE;
`endif
                        end
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
`ifdef PIECE_CAPTURE_EN
            CAPTURE: begin
                // Landing on the opponent (outside the start cell) sends it home.
                if ((p1_q == p2_q) && (p1_q != 6'd0)) begin
                    if (player_q) p1_d = 6'd0;
                    else          p2_d = 6'd0;
                end
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any move without a done pulse.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            player_q <= 1'b0;
            steps_q  <= 4'd0;
            frame_q  <= 8'd0;
            p1_q     <= 6'd0;
            p2_q     <= 6'd0;
            ready_q  <= 1'b1;
            moving_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            steps_q  <= steps_d;
            frame_q  <= frame_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            ready_q  <= (state_d == IDLE);
            moving_q <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign mv.oMove_Ready = ready_q;
    assign mv.oMoving     = moving_q;
    assign mv.oMove_Done  = done_q;
    assign oP1_Pos        = p1_q;
    assign oP2_Pos        = p2_q;

endmodule

// File: tb/tb_piece_move_animator.sv
// Scoreboard bench for piece_move_animator (NUM_CELLS=28, FRAMES_PER_STEP=2).
// Stimulus pushes expected position changes and done pulses; a negedge
// monitor pops and compares whenever the DUT shows a change or a done pulse.
module tb_piece_move_animator;

    localparam int NC  = 28;
    localparam int FPS = 2;
    localparam int MS  = 6;
`ifdef PIECE_CAPTURE_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 0;
`endif

    typedef struct {
        int p1;
        int p2;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [5:0] p1_pos, p2_pos;

    piece_move_animator_if mv_if ();

    piece_move_animator #(
        .NUM_CELLS       (NC),
        .FRAMES_PER_STEP (FPS),
        .MAX_STEPS       (MS)
    ) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iFrame_Tick (frame_tick),
        .mv          (mv_if),
        .oP1_Pos     (p1_pos),
        .oP2_Pos     (p2_pos)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   last_p1 = 0;
    int   last_p2 = 0;
    int   e1 = 0;
    int   e2 = 0;
    exp_t pos_q[$];
    exp_t done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pos(input int a, input int b, input int c);
        exp_t e;
        e.p1 = a; e.p2 = b; e.cyc = c;
        pos_q.push_back(e);
    endtask

    task automatic push_done(input int a, input int b, input int c);
        exp_t e;
        e.p1 = a; e.p2 = b; e.cyc = c;
        done_q.push_back(e);
    endtask

    // Monitor: compare every observed position change and every done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(p1_pos) != last_p1 || int'(p2_pos) != last_p2) begin
                if (pos_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pos_unexpected: got %0d/%0d, required no change (cycle %0d)",
                             p1_pos, p2_pos, cyc);
                end else begin
                    exp_t e;
                    e = pos_q.pop_front();
                    check("pos_p1", int'(p1_pos), e.p1);
                    check("pos_p2", int'(p2_pos), e.p2);
                    check("pos_cycle", cyc, e.cyc);
                end
                last_p1 = int'(p1_pos);
                last_p2 = int'(p2_pos);
            end
            if (mv_if.oMove_Done) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_unexpected: got done=1, required 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    check("done_p1", int'(p1_pos), e.p1);
                    check("done_p2", int'(p2_pos), e.p2);
                    check("done_cycle", cyc, e.cyc);
                    check("moving_at_done", int'(mv_if.oMoving), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic send_move(input bit pl, input int st, input bit tk, output int acc);
        bit ok;
        @(posedge clk); #1;
        mv_if.iMove_Valid  = 1'b1;
        mv_if.iMove_Player = pl;
        mv_if.iMove_Steps  = 4'(st);
        frame_tick         = tk;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mv_if.oMove_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0, required 1 within 50 cycles");
        end
        @(posedge clk); #1;
        mv_if.iMove_Valid = 1'b0;
        frame_tick        = 1'b0;
        acc = cyc;
    endtask

    task automatic advance(input bit pl);
        if (pl) e2 = (e2 + 1) % NC;
        else    e1 = (e1 + 1) % NC;
    endtask

    // One complete move; hops is the hand-computed number of cells expected.
    task automatic run_move(input bit pl, input int req, input int hops,
                            input bit tick_at_accept, input bit poke_busy);
        int  acc;
        bit  ok;
        send_move(pl, req, tick_at_accept, acc);
        if (hops == 0) begin
            push_done(e1, e2, acc);
        end else begin
            for (int k = 1; k <= hops * FPS; k++) begin
                tick();
                if (k % FPS == 0) begin
                    advance(pl);
                    push_pos(e1, e2, cyc);
                    if (k == hops * FPS) begin
`ifdef PIECE_CAPTURE_EN
                        if (e1 == e2 && e1 != 0) begin
                            if (pl) e1 = 0;
                            else    e2 = 0;
                            push_pos(e1, e2, cyc + 1);
                        end
`endif
                        push_done(e1, e2, cyc + DONE_LAT);
                    end
                end
                if (poke_busy && k == 1) begin
                    @(posedge clk); #1;
                    mv_if.iMove_Valid  = 1'b1;
                    mv_if.iMove_Player = ~pl;
                    mv_if.iMove_Steps  = 4'd5;
                    @(negedge clk);
                    check("ready_while_moving", int'(mv_if.oMove_Ready), 0);
                    check("moving_flag", int'(mv_if.oMoving), 1);
                    @(posedge clk); #1;
                    mv_if.iMove_Valid = 1'b0;
                end
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mv_if.oMoving) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL moving_timeout: got moving=1, required 0 within 20 cycles");
        end
        check("ready_after_move", int'(mv_if.oMove_Ready), 1);
        // Idle ticks must not move anything.
        tick();
        tick();
    endtask

    initial begin
        int acc;
        mv_if.iMove_Valid  = 1'b0;
        mv_if.iMove_Player = 1'b0;
        mv_if.iMove_Steps  = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_p1", int'(p1_pos), 0);
        check("rst_p2", int'(p2_pos), 0);
        check("rst_ready", int'(mv_if.oMove_Ready), 1);
        check("rst_done", int'(mv_if.oMove_Done), 0);
        check("rst_moving", int'(mv_if.oMoving), 0);
        last_p1 = 0;
        last_p2 = 0;
        mon_en  = 1'b1;

        // P1 moves 3 with a tick in the accept cycle (not counted).
        run_move(1'b0, 3, 3, 1'b1, 1'b0);
        // Zero-step move: done right after accept, no hop.
        run_move(1'b0, 0, 0, 1'b0, 1'b0);
        // Request 9 is clamped to 6 hops.
        run_move(1'b1, 9, 6, 1'b0, 1'b0);
        // Walk P2 up to cell 26.
        run_move(1'b1, 6, 6, 1'b0, 1'b0);
        run_move(1'b1, 6, 6, 1'b0, 1'b0);
        run_move(1'b1, 6, 6, 1'b0, 1'b0);
        run_move(1'b1, 2, 2, 1'b0, 1'b0);
        check("p2_at_26", int'(p2_pos), 26);
        // Wrap: 26 -> 27, 0, 1, 2.
        run_move(1'b1, 4, 4, 1'b0, 1'b0);
        check("p2_wrapped", int'(p2_pos), 2);
        // Request pulsed while busy is ignored; P1 3 -> 5 only.
        run_move(1'b0, 2, 2, 1'b0, 1'b1);
        check("p1_after_busy_poke", int'(p1_pos), 5);
        check("p2_after_busy_poke", int'(p2_pos), 2);

        // Reset after the 2nd of 5 hops aborts the move.
        send_move(1'b0, 5, 1'b0, acc);
        for (int k = 1; k <= 2 * FPS; k++) begin
            tick();
            if (k % FPS == 0) begin
                advance(1'b0);
                push_pos(e1, e2, cyc);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        e1 = 0;
        e2 = 0;
        push_pos(0, 0, cyc);
        @(negedge clk);
        check("abort_ready", int'(mv_if.oMove_Ready), 1);
        check("abort_moving", int'(mv_if.oMoving), 0);
        check("abort_p1", int'(p1_pos), 0);
        repeat (20) @(posedge clk);

        // Capture scenario: P2 to 5, P1 to 2, then P1 lands on 5.
        run_move(1'b1, 5, 5, 1'b0, 1'b0);
        run_move(1'b0, 2, 2, 1'b0, 1'b0);
        run_move(1'b0, 3, 3, 1'b0, 1'b0);
        check("capture_p1", int'(p1_pos), 5);
`ifdef PIECE_CAPTURE_EN
        check("capture_p2", int'(p2_pos), 0);
`else
        check("capture_p2", int'(p2_pos), 5);
`endif

        repeat (5) @(posedge clk);
        check("pos_queue_left", pos_q.size(), 0);
        check("done_queue_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish before 500000 ns");
        $fatal(1, "timeout");
    end

endmodule
